// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
// Holds the FSM state encoding and the default requester/hold parameters.
package arb_pkg;

  localparam int ARB_EXP_DEFAULT      = 3;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: first set request at or after ptr, wrapping N-1 -> 0.
// Purely combinational; the arbiter registers whatever it selects.
module rr_pick
  import arb_pkg::*;
#(
  parameter int EXP = ARB_EXP_DEFAULT
) (
  input  logic [(2**EXP)-1:0] req,
  input  logic [EXP-1:0]      ptr,
  output logic                found,
  output logic [EXP-1:0]      idx
);

  localparam int N = 2**EXP;

  // Candidate index arithmetic is EXP bits wide, so ptr + k wraps on its own.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[ptr + EXP'(k)]) begin
        found = 1'b1;
        idx   = ptr + EXP'(k);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Locked round-robin arbiter: one grant at a time, released by done or by a hold timeout.
// grant_idx is a plain register meant to drive the select of a shared N:1 mux tree.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int EXP      = ARB_EXP_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [(2**EXP)-1:0] req,
  input  logic                done,
  output logic                grant_valid,
  output logic [EXP-1:0]      grant_idx,
  output logic [(2**EXP)-1:0] grant,
  output logic                timeout
);

  localparam int N      = 2**EXP;
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  if (EXP < 1) begin : g_bad_exp
    $error("rr_mux_arbiter: EXP must be at least 1");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_mux_arbiter: MAX_HOLD must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [EXP-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [EXP-1:0]    grant_idx_q, grant_idx_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [EXP-1:0]    pick_idx;

  rr_pick #(
    .EXP (EXP)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    grant_idx_d   = grant_idx_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = BUSY;
          grant_idx_d   = pick_idx;
          hold_d        = '0;
          grant_valid_d = 1'b1;
          grant_d       = N'(1) << pick_idx;
        end
      end

      BUSY: begin
        // The grant is locked: req is ignored here; only done or the hold limit ends it.
        if (done || (hold_q == HOLD_LAST)) begin
          state_d       = IDLE;
          ptr_d         = grant_idx_q + EXP'(1);
          hold_d        = '0;
          grant_valid_d = 1'b0;
          grant_d       = '0;
          timeout_d     = !done;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        grant_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_q        <= '0;
      grant_idx_q   <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      grant_idx_q   <= grant_idx_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant       = grant_q;
  assign timeout     = timeout_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    grant_valid_q |-> (grant_q == (N'(1) << grant_idx_q)));

  a_grant_zero_idle : assert property (@(posedge clk) disable iff (!reset_n)
    !grant_valid_q |-> (grant_q == '0));

  a_timeout_on_release : assert property (@(posedge clk) disable iff (!reset_n)
    timeout_q |-> !grant_valid_q);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a cycle-level reference model predicts grant and
// release events with their arrival cycle; an independent monitor compares what the DUT shows.
module tb_rr_mux_arbiter;
  import arb_pkg::*;

  localparam int EXP      = ARB_EXP_DEFAULT;
  localparam int N        = 2**EXP;
  localparam int MAX_HOLD = ARB_MAX_HOLD_DEFAULT;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           done = 1'b0;
  logic           grant_valid;
  logic [EXP-1:0] grant_idx;
  logic [N-1:0]   grant;
  logic           timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit is_grant;
    int idx;
    bit to;
    int cyc;
  } ev_t;

  ev_t sb_q[$];

  // Reference model state: who owns the bus, where the search starts, how long it has been held.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  rr_mux_arbiter #(
    .EXP      (EXP),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant       (grant),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Predict what the coming clock edge does; observable events are stamped with that edge's cycle.
  task automatic model_edge(input logic [N-1:0] r, input logic d);
    ev_t ev;
    if (!m_busy) begin
      if (r != '0) begin
        m_owner = first_from(r, m_ptr);
        m_busy  = 1'b1;
        m_held  = 1;
        ev = '{1'b1, m_owner, 1'b0, cyc + 1};
        sb_q.push_back(ev);
      end
    end else if (d || m_held == MAX_HOLD) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
      ev = '{1'b0, m_owner, !d, cyc + 1};
      sb_q.push_back(ev);
    end else begin
      m_held++;
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_held = 0;
  endtask

  task automatic step(input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    model_edge(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, grant_valid, 1'b0);
    check({tag, "_grant"}, grant, '0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_idx"}, grant_idx, '0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req     = '0;
    done    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: sees only DUT pins and the scoreboard queue.
  bit             prev_valid = 1'b0;
  logic [EXP-1:0] prev_idx   = '0;
  ev_t            mon_ev;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      check("grant_vec", grant, grant_valid ? (N'(1) << grant_idx) : '0);
      if (grant_valid && prev_valid) check("idx_locked", grant_idx, prev_idx);
      if (grant_valid && !prev_valid) begin
        check("sb_grant_expected", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          mon_ev = sb_q.pop_front();
          check("ev_is_grant", mon_ev.is_grant, 1'b1);
          check("grant_idx", grant_idx, mon_ev.idx);
          check("grant_cycle", cyc, mon_ev.cyc);
        end
      end else if (!grant_valid && prev_valid) begin
        check("sb_release_expected", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          mon_ev = sb_q.pop_front();
          check("ev_is_release", mon_ev.is_grant, 1'b0);
          check("release_idx_held", grant_idx, mon_ev.idx);
          check("release_timeout", timeout, mon_ev.to);
          check("release_cycle", cyc, mon_ev.cyc);
        end
      end else begin
        check("timeout_quiet", timeout, 1'b0);
      end
      prev_valid = grant_valid;
      prev_idx   = grant_idx;
    end
  end

  initial begin
    apply_reset();

    // done while idle with no requests changes nothing
    repeat (3) step('0, 1'b1);
    check_quiet("idle_done");

    // basic grant, bubble, then next requester after the pointer
    step(8'b0000_0101, 1'b0);
    check("basic_valid", grant_valid, 1'b1);
    check("basic_idx", grant_idx, 0);
    check("basic_grant", grant, 8'b0000_0001);
    step(8'b0000_0101, 1'b1);
    check("basic_bubble", grant_valid, 1'b0);
    step(8'b0000_0101, 1'b0);
    check("basic_next_idx", grant_idx, 2);
    step('0, 1'b1);

    // full sweep from a fresh reset
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      check("sweep_idx", grant_idx, i % N);
      step(8'hFF, 1'b1);
      check("sweep_bubble", grant_valid, 1'b0);
    end

    // pointer wraps past N-1
    step(8'h40, 1'b0);
    step('0, 1'b1);
    step(8'b0000_0011, 1'b0);
    check("wrap_idx", grant_idx, 0);
    step('0, 1'b1);

    // locked grant with the requester gone: forced release after MAX_HOLD busy cycles
    step(8'h10, 1'b0);
    repeat (MAX_HOLD - 1) step('0, 1'b0);
    check("hold_still_locked", grant_valid, 1'b1);
    check("hold_no_timeout_yet", timeout, 1'b0);
    step('0, 1'b0);
    check("hold_timeout_pulse", timeout, 1'b1);
    check("hold_released", grant_valid, 1'b0);
    step('0, 1'b0);
    check("hold_timeout_one_cycle", timeout, 1'b0);

    // asynchronous reset in the middle of a grant
    step(8'h08, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_quiet("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(8'h80, 1'b0);
    check("post_rst_idx", grant_idx, 7);
    step('0, 1'b1);

    // randomized traffic: frequent done first, then rare done to exercise timeouts
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      logic         d;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(0, N - 1);
        2:       r = N'($urandom);
        default: r = N'($urandom & $urandom);
      endcase
      if (i < 1500) d = ($urandom_range(0, 2) == 0);
      else          d = ($urandom_range(0, 29) == 0);
      step(r, d);
    end

    repeat (4) step('0, 1'b1);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter EXP, default 3, meaning log2 of requester count N = 2**EXP; EXP >= 1, checked by an initial assertion.
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning the maximum cycles one grant is held before forced release; MAX_HOLD >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, N bits: one request bit per requester; bit i is requester i.
REQ-006 SHALL have port done, input, 1 bit: the granted requester finishes its transfer this cycle.
REQ-007 SHALL have port grant_valid, output, 1 bit: a grant is active.
REQ-008 SHALL have port grant_idx, output, EXP bits: index of the granted requester, driving the select of the shared N:1 mux tree.
REQ-009 SHALL have port grant, output, N bits: one-hot grant; all zero when grant_valid is low.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-012 IDLE: when req != 0, SHALL pick the first set req bit at or after pointer ptr (ascending, wrapping N-1 -> 0), load grant_idx, and enter BUSY next edge.
REQ-013 Latency: req set in cycle t with arbiter IDLE SHALL give grant_valid=1 in cycle t+1.
REQ-014 BUSY: grant_valid=1, grant = one-hot of grant_idx, and grant_idx SHALL stay stable until release.
REQ-015 A grant SHALL be locked: deasserting req of the granted requester SHALL NOT release it; only done or timeout releases it.
REQ-016 done=1 in BUSY SHALL return the FSM to IDLE next edge, set ptr = (grant_idx+1) mod N, and drop grant_valid in the following cycle; no back-to-back grant, one IDLE bubble minimum.
REQ-017 done in IDLE SHALL be ignored.
REQ-018 Hold counter SHALL clear on entering BUSY and increment each BUSY cycle; when it reaches MAX_HOLD-1 without done, the FSM SHALL release exactly as for done and pulse timeout for one cycle.
REQ-019 done and timeout condition in the same cycle SHALL count as a normal done; timeout stays 0.
REQ-020 Pointer arithmetic SHALL be EXP bits wide and wrap naturally from N-1 to 0.
REQ-021 grant_idx SHALL hold its last value while IDLE; grant SHALL be zero while IDLE.
REQ-022 req bits changing during BUSY SHALL have no effect until the next IDLE cycle.

Reset
REQ-023 reset_n low SHALL immediately force: FSM IDLE, ptr=0, hold counter 0, grant_idx=0, grant=0, grant_valid=0, timeout=0.
REQ-024 Reset asserted mid-grant SHALL drop the grant asynchronously, with no done or timeout pulse.
REQ-025 After reset_n rises, the first arbitration SHALL start from requester 0.

Structure
REQ-026 Shared package arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the default EXP and MAX_HOLD constants.
REQ-027 A combinational sub-module rr_pick (inputs req and ptr; outputs found and idx) SHALL implement the rotated priority search. The FSM, counter and pointer stay in rr_mux_arbiter.
REQ-028 grant_idx SHALL be registered and connect directly to the mux tree sel input with no extra logic.

Verification (EXP=3, MAX_HOLD=16)
REQ-029 Reset, then req=8'b0000_0101 -> next cycle grant_valid=1, grant_idx=0, grant=8'b0000_0001; done pulse -> IDLE bubble, then grant_idx=2.
REQ-030 req=8'hFF held, done after every grant -> grant_idx sequence 0,1,2,...,7,0 with one IDLE cycle between grants.
REQ-031 ptr=7 (after granting 6), req=8'b0000_0011 -> grant_idx=0 (wrap).
REQ-032 Granted requester drops req with no done for 15 BUSY cycles -> grant stays locked; on the 16th BUSY cycle timeout=1 for one cycle, then IDLE.
REQ-033 Drive reset_n=0 mid-grant, between clock edges -> grant, grant_valid=0 immediately; after release, req=8'h80 -> grant_idx=7.
REQ-034 done=1 while IDLE with req=0 -> no state change, all outputs 0.
